r2_mul_issue_ctrl: RTL and testbench

//  Upstream feeder for the radix-2 shift-add multiplier. Buffers operand pairs

---
 rtl/r2_mul_issue_ctrl.sv | 118 +++++++++++
 tb/tb_r2_mul_issue_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r2_mul_issue_ctrl.sv
// Operand FIFO and issue controller for the radix-2 shift-add multiplier.
// One product is outstanding at a time. A watchdog turns a lost product into an error result.
module r2_mul_issue_ctrl #(
  parameter int DWIDTH  = 8,
  parameter int OWIDTH  = 2*DWIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DWIDTH-1:0]        s_x,
  input  logic [DWIDTH-1:0]        s_y,
  output logic                     mul_i_valid,
  output logic [DWIDTH-1:0]        mul_x,
  output logic [DWIDTH-1:0]        mul_y,
  input  logic [OWIDTH-1:0]        mul_z,
  input  logic                     mul_o_valid,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OWIDTH-1:0]        m_z,
  output logic                     m_err,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                  state;
  logic [2*DWIDTH-1:0]     mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic [TW-1:0]           wait_cnt;
  logic [TW-1:0]           wait_inc;
  logic                    push;
  logic                    pop;

  assign s_ready    = (count < CW'(DEPTH));
  assign push       = s_valid && s_ready;
  assign pop        = (state == IDLE) && (count != '0) && !m_valid;
  assign fifo_count = count;
  assign busy       = (state != IDLE);
  assign wait_inc   = wait_cnt + TW'(1);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_x, s_y};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The watchdog compares the incremented count, so the ISSUE cycle is counted and
  // an error result appears exactly TIMEOUT cycles after the start pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      mul_i_valid <= 1'b0;
      mul_x       <= '0;
      mul_y       <= '0;
      wait_cnt    <= '0;
      m_valid     <= 1'b0;
      m_z         <= '0;
      m_err       <= 1'b0;
    end else begin
      mul_i_valid <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            {mul_x, mul_y} <= mem[rd_ptr];
            mul_i_valid    <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_inc;
          if (mul_o_valid) begin
            m_z     <= mul_z;
            m_err   <= 1'b0;
            m_valid <= 1'b1;
            state   <= IDLE;
          end else if (wait_inc == TW'(TIMEOUT - 1)) begin
            m_z     <= '0;
            m_err   <= 1'b1;
            m_valid <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r2_mul_issue_ctrl.sv
// Bench for r2_mul_issue_ctrl: behavioural multiplier stub plus queue-based product model.
module tb_r2_mul_issue_ctrl;

  localparam int DW = 8;
  localparam int OW = 16;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 32;

  logic clk, rstn;
  logic s_valid, s_ready;
  logic [DW-1:0] s_x, s_y;
  logic mul_i_valid;
  logic [DW-1:0] mul_x, mul_y;
  logic [OW-1:0] mul_z;
  logic mul_o_valid;
  logic m_valid, m_ready;
  logic [OW-1:0] m_z;
  logic m_err;
  logic [$clog2(DEPTH):0] fifo_count;
  logic busy;

  int vectors = 0;
  int miscompares = 0;

  r2_mul_issue_ctrl #(.DWIDTH(DW), .OWIDTH(OW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
    .mul_i_valid(mul_i_valid), .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
    .mul_o_valid(mul_o_valid), .m_valid(m_valid), .m_ready(m_ready), .m_z(m_z),
    .m_err(m_err), .fifo_count(fifo_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier stub: product pulse mul_delay cycles after the start pulse; delay < 2 never answers.
  int mul_delay = 10;
  int stub_cnt = -1;
  logic stub_valid = 1'b0;
  logic [OW-1:0] stub_z = '0;
  logic stray_valid = 1'b0;
  logic [OW-1:0] stray_z = '0;
  assign mul_o_valid = stub_valid | stray_valid;
  assign mul_z = stray_valid ? stray_z : stub_z;

  always @(posedge clk) begin
    if (!rstn) begin
      stub_cnt = -1;
      stub_valid <= 1'b0;
      stub_z <= '0;
    end else begin
      stub_valid <= 1'b0;
      if (stub_cnt > 0) stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0) begin
        stub_valid <= 1'b1;
        stub_z <= {8'd0, mul_x} * {8'd0, mul_y};
        stub_cnt = -1;
      end
      if (mul_i_valid) stub_cnt = (mul_delay >= 2) ? mul_delay - 1 : -1;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  // All tasks are entered and left at a falling edge.
  task automatic push_pair(input logic [DW-1:0] x, input logic [DW-1:0] y);
    bit ok;
    int guard = 0;
    s_x = x; s_y = y; s_valid = 1'b1;
    do begin
      ok = s_ready;
      @(negedge clk);
      guard++;
    end while (!ok && guard < 200);
    s_valid = 1'b0;
    if (!ok) begin
      vectors++; miscompares++;
      $display("[TB] FAIL push_accept: s_ready=%0b, expected 1 within 200 cycles", s_ready);
    end
  endtask

  task automatic wait_for_m_valid();
    int guard = 0;
    while (m_valid !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    if (m_valid !== 1'b1) begin
      vectors++; miscompares++;
      $display("[TB] FAIL wait_m_valid: m_valid=%0b, expected 1 within 100 cycles", m_valid);
    end
  endtask

  task automatic wait_for_issue();
    int guard = 0;
    while (mul_i_valid !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    if (mul_i_valid !== 1'b1) begin
      vectors++; miscompares++;
      $display("[TB] FAIL wait_issue: mul_i_valid=%0b, expected 1 within 100 cycles", mul_i_valid);
    end
  endtask

  task automatic consume();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_x = '0; s_y = '0;
    repeat (3) @(negedge clk);
    vectors++; if (fifo_count !== 0) begin miscompares++; $display("[TB] FAIL rst_count: got %0d expected 0", fifo_count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %0b expected 0", busy); end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_m_valid: got %0b expected 0", m_valid); end
    vectors++; if (mul_i_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_i_valid: got %0b expected 0", mul_i_valid); end
    vectors++; if (mul_x !== 0 || mul_y !== 0) begin miscompares++; $display("[TB] FAIL rst_mul_xy: got %0d,%0d expected 0,0", mul_x, mul_y); end
    vectors++; if (m_z !== 0 || m_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_m_z_err: got %0d,%0b expected 0,0", m_z, m_err); end
    rstn = 1'b1;
    @(negedge clk);
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_s_ready: got %0b expected 1", s_ready); end
  endtask

  task automatic test_single_op();
    m_ready = 1'b0; mul_delay = 10;
    push_pair(8'd13, 8'd11);
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) @(negedge clk);
      vectors++;
      if (mul_i_valid !== (k == 2)) begin miscompares++; $display("[TB] FAIL single_i_valid c%0d: got %0b expected %0b", k, mul_i_valid, k == 2); end
      vectors++;
      if (m_valid !== (k >= 13)) begin miscompares++; $display("[TB] FAIL single_m_valid c%0d: got %0b expected %0b", k, m_valid, k >= 13); end
      vectors++;
      if (busy !== (k >= 2 && k <= 12)) begin miscompares++; $display("[TB] FAIL single_busy c%0d: got %0b expected %0b", k, busy, (k >= 2 && k <= 12)); end
    end
    vectors++; if (m_z !== 16'd143 || m_err !== 1'b0) begin miscompares++; $display("[TB] FAIL single_result: got %0d err %0b expected 143 err 0", m_z, m_err); end
    consume();
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_drain: got %0b expected 0", m_valid); end
  endtask

  task automatic test_full_fifo();
    logic [DW-1:0] xs [6];
    logic [DW-1:0] ys [6];
    int exp_z [6];
    int got = 0, guard = 0;
    bit acc;
    xs[0] = 8'd3; ys[0] = 8'd5; xs[1] = 8'd255; ys[1] = 8'd255;
    for (int i = 2; i < 6; i++) begin xs[i] = DW'($urandom); ys[i] = DW'($urandom); end
    for (int i = 0; i < 6; i++) exp_z[i] = int'(xs[i]) * int'(ys[i]);
    m_ready = 1'b0; mul_delay = 10;
    for (int i = 0; i < 5; i++) push_pair(xs[i], ys[i]);
    repeat (16) @(negedge clk);
    vectors++; if (fifo_count !== DEPTH) begin miscompares++; $display("[TB] FAIL full_count: got %0d expected %0d", fifo_count, DEPTH); end
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_s_ready: got %0b expected 0", s_ready); end
    vectors++; if (m_valid !== 1'b1 || m_z !== 16'd15) begin miscompares++; $display("[TB] FAIL full_first: got v%0b z%0d expected v1 z15", m_valid, m_z); end
    s_x = xs[5]; s_y = ys[5]; s_valid = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (fifo_count !== DEPTH) begin miscompares++; $display("[TB] FAIL full_no_push: got %0d expected %0d", fifo_count, DEPTH); end
    m_ready = 1'b1;
    while (got < 6 && guard < 400) begin
      acc = s_valid && s_ready;
      if (m_valid && m_ready) begin
        vectors++;
        if (m_z !== OW'(exp_z[got]) || m_err !== 1'b0) begin miscompares++; $display("[TB] FAIL full_order #%0d: got %0d err %0b expected %0d err 0", got, m_z, m_err, exp_z[got]); end
        got++;
      end
      @(negedge clk); guard++;
      if (acc) s_valid = 1'b0;
    end
    m_ready = 1'b0; s_valid = 1'b0;
    vectors++; if (got != 6) begin miscompares++; $display("[TB] FAIL full_drain: got %0d results expected 6", got); end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0; mul_delay = 10;
    push_pair(8'd7, 8'd9);
    push_pair(8'd20, 8'd30);
    wait_for_m_valid();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vectors++;
      if (m_valid !== 1'b1 || m_z !== 16'd63 || mul_i_valid !== 1'b0) begin
        miscompares++; $display("[TB] FAIL bp_hold c%0d: got v%0b z%0d i%0b expected v1 z63 i0", k, m_valid, m_z, mul_i_valid);
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    vectors++; if (m_valid !== 1'b0 || mul_i_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_release: got v%0b i%0b expected v0 i0", m_valid, mul_i_valid); end
    @(negedge clk);
    vectors++; if (mul_i_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_next_issue: got %0b expected 1", mul_i_valid); end
    wait_for_m_valid();
    vectors++; if (m_z !== 16'd600 || m_err !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_second: got %0d err %0b expected 600 err 0", m_z, m_err); end
    consume();
  endtask

  task automatic test_timeout();
    m_ready = 1'b0; mul_delay = 0;
    push_pair(8'd5, 8'd6);
    wait_for_issue();
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      vectors++;
      if (m_valid !== (k == TIMEOUT)) begin miscompares++; $display("[TB] FAIL to_latency c%0d: got %0b expected %0b", k, m_valid, k == TIMEOUT); end
    end
    vectors++; if (m_err !== 1'b1 || m_z !== 0) begin miscompares++; $display("[TB] FAIL to_result: got z%0d err %0b expected z0 err 1", m_z, m_err); end
    consume();
    mul_delay = 10;
    push_pair(8'd12, 8'd12);
    wait_for_m_valid();
    vectors++; if (m_z !== 16'd144 || m_err !== 1'b0) begin miscompares++; $display("[TB] FAIL to_recover: got %0d err %0b expected 144 err 0", m_z, m_err); end
    consume();
  endtask

  task automatic test_stray_coincident();
    m_ready = 1'b0;
    stray_z = 16'h1234; stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL stray c%0d: got v%0b busy%0b expected v0 busy0", k, m_valid, busy); end
    end
    mul_delay = TIMEOUT - 1;
    push_pair(8'd200, 8'd3);
    wait_for_issue();
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      vectors++;
      if (m_valid !== (k == TIMEOUT)) begin miscompares++; $display("[TB] FAIL coinc_latency c%0d: got %0b expected %0b", k, m_valid, k == TIMEOUT); end
    end
    vectors++; if (m_err !== 1'b0 || m_z !== 16'd600) begin miscompares++; $display("[TB] FAIL coinc_result: got z%0d err %0b expected z600 err 0", m_z, m_err); end
    consume();
    mul_delay = 10;
  endtask

  task automatic test_reset_midop();
    m_ready = 1'b0; mul_delay = 10;
    push_pair(8'd1, 8'd2); push_pair(8'd3, 8'd4); push_pair(8'd5, 8'd6); push_pair(8'd7, 8'd8);
    vectors++; if (fifo_count !== 3 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_pre: got count %0d busy %0b expected 3 1", fifo_count, busy); end
    rstn = 1'b0;
    @(negedge clk);
    vectors++; if (fifo_count !== 0 || m_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst: got count %0d v%0b busy%0b expected 0 0 0", fifo_count, m_valid, busy); end
    @(negedge clk);
    rstn = 1'b1;
    repeat (15) @(negedge clk);
    vectors++; if (m_valid !== 1'b0 || fifo_count !== 0) begin miscompares++; $display("[TB] FAIL mid_stale: got v%0b count %0d expected v0 count 0", m_valid, fifo_count); end
    push_pair(8'd0, 8'd200);
    wait_for_m_valid();
    vectors++; if (m_z !== 0 || m_err !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_zero: got z%0d err %0b expected z0 err 0", m_z, m_err); end
    consume();
  endtask

  task automatic test_random();
    int exp_q [$];
    int n_ops = 25, planned = 0, got = 0, guard = 0, e;
    bit acc = 0, hs;
    s_valid = 1'b0; m_ready = 1'b0;
    while (got < n_ops && guard < 4000) begin
      @(negedge clk); guard++;
      if (acc) s_valid = 1'b0;
      mul_delay = int'($urandom_range(20, 2));
      m_ready = ($urandom_range(3, 0) != 0);
      if (!s_valid && planned < n_ops && $urandom_range(1, 0) == 1) begin
        s_x = DW'($urandom); s_y = DW'($urandom); s_valid = 1'b1; planned++;
      end
      acc = s_valid && s_ready;
      if (acc) exp_q.push_back(int'(s_x) * int'(s_y));
      hs = m_valid && m_ready;
      if (hs) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("[TB] FAIL rand_extra: got result %0d expected none", m_z);
        end else begin
          e = exp_q.pop_front();
          if (m_z !== OW'(e) || m_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rand_result #%0d: got %0d err %0b expected %0d err 0", got, m_z, m_err, e); end
        end
        got++;
      end
    end
    @(negedge clk);
    s_valid = 1'b0; m_ready = 1'b0;
    vectors++; if (got != n_ops) begin miscompares++; $display("[TB] FAIL rand_count: got %0d results expected %0d", got, n_ops); end
  endtask

  initial begin
    rstn = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_x = '0; s_y = '0;
    test_reset();
    test_single_op();
    test_full_fifo();
    test_backpressure();
    test_timeout();
    test_stray_coincident();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
